sum_accumulator: RTL and testbench
==================================

Name: sum_accumulator

Overview:
- Sequential stage directly downstream of the ripple-carry adder.
- Consumes the adder's WIDTH+1-bit sum over a valid/ready handshake and accumulates COUNT consecutive sums into one total.
- Presents the total on a valid/ready output and flags overflow.
- Used for multi-operand summation and frame averaging built on the combinational adder.

Parameters:
- WIDTH, 10: adder operand width; input sum is WIDTH+1 bits.
- COUNT, 4: sums per frame; legal range ≥1.
- ACC_WIDTH, 13: accumulator/total width; must be ≥ WIDTH+1.

Ports:
- i_clk  input  1  clock, rising-edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_sum  input  WIDTH+1  sum from adder, unsigned.
- i_valid  input  1  i_sum valid.
- o_ready  output  1  stage can accept i_sum.
- i_clear  input  1  synchronous frame abort.
- o_total  output  ACC_WIDTH  accumulated frame total.
- o_valid  output  1  o_total valid.
- i_ready  input  1  consumer accepts o_total.
- o_count  output  clog2(COUNT+1)  beats accepted in the current frame.
- o_overflow  output  1  frame overflowed ACC_WIDTH; valid with o_valid.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous, active-high.
- Reset values: state=IDLE, accumulator=0, o_count=0, o_total=0, o_valid=0, o_overflow=0, o_ready=1.
- Accept condition: a beat is accepted on a rising edge when i_valid && o_ready. i_sum is zero-extended to ACC_WIDTH+1 and added to the accumulator.
- States:
  - IDLE: o_count=0, o_ready=1. An accepted beat moves to ACCUM, or to HOLD if COUNT=1.
  - ACCUM: o_ready=1. Each accepted beat increments o_count. The beat that brings o_count to COUNT moves to HOLD.
  - HOLD: o_ready=0, o_valid=1. o_total and o_overflow stay stable until i_ready. On i_valid... no input is taken here; on the i_ready handshake edge: accumulator=0, o_count=0, o_overflow=0, o_valid=0, state=IDLE. o_ready is 1 from the next cycle.
- Latency: o_valid rises the cycle after the COUNT-th accepted beat. o_total includes that beat.
- Throughput: best case COUNT beats + 1 HOLD cycle per frame, with i_ready tied high.
- Output back-pressure: i_ready low holds HOLD indefinitely. Input is back-pressured through o_ready=0.
- o_total is registered. It equals the running accumulator in IDLE/ACCUM and is frozen in HOLD.
- Overflow: set sticky when any addition within the frame produces a carry out of bit ACC_WIDTH-1. The wrapped value is kept (mod 2^ACC_WIDTH) unless the optional feature is enabled.
- i_clear (synchronous):
  - Any state → accumulator=0, o_count=0, o_overflow=0, o_valid=0, IDLE.
  - Has priority over a simultaneous input accept and over an output handshake. The beat or result is discarded.
- Reset mid-frame: the partial sum is lost. No output is produced.
- i_valid with o_ready=0: no effect. The upstream holds the data.

Optional Feature:
- Macro: SUM_ACCUMULATOR_SAT_EN.
- Defined: on overflow the accumulator clamps to all-ones (2^ACC_WIDTH-1) and stays there for the rest of the frame. o_overflow is still set.
- Undefined: the accumulator wraps modulo 2^ACC_WIDTH and o_overflow is set.
- Handshake, latency and all other behaviour are identical in both builds.

Test Plan:
1. Defaults, i_ready=1. Beats 100, 200, 300, 400 back-to-back → o_valid one cycle after the 4th beat, o_total=1000, o_overflow=0. o_ready=0 for exactly one cycle.
2. Defaults. Four beats of 2046 → o_total=8184, o_overflow=0 (fits 13 bits).
3. ACC_WIDTH=12, four beats of 2046:
   - Without SAT_EN → o_total=4088, o_overflow=1.
   - With SAT_EN → o_total=4095, o_overflow=1.
4. Back-pressure:
   - Frame completes with i_ready=0 for 5 cycles → o_valid and o_total stable, o_ready=0, and i_valid beats are ignored.
   - Raise i_ready → handshake. The next frame starts from 0 and its beats 1,1,1,1 → o_total=4.
5. Abort: after 2 beats (10, 20), pulse i_clear coincident with a 3rd beat of 30 → o_count=0, beat dropped. The next four beats of 5 → o_total=20.
6. Reset and COUNT=1:
   - Assert i_rst asynchronously mid-frame → all outputs reach reset values without a clock edge.
   - With COUNT=1, a single beat of 7 → o_valid next cycle, o_total=7.

Source files
------------

// File: rtl/sum_accumulator.sv
// Accumulates COUNT consecutive adder sums into one frame total with a sticky overflow flag.
// Optional build macro SUM_ACCUMULATOR_SAT_EN clamps the total to all-ones on overflow instead of wrapping.
module sum_accumulator #(
  parameter int WIDTH     = 10,
  parameter int COUNT     = 4,
  parameter int ACC_WIDTH = 13
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [WIDTH:0]             i_sum,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic                       i_clear,
  output logic [ACC_WIDTH-1:0]       o_total,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(COUNT+1)-1:0] o_count,
  output logic                       o_overflow
);
  localparam int CW  = $clog2(COUNT+1);
  localparam int AW1 = ACC_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t               state, state_nxt;
  logic [ACC_WIDTH-1:0] acc, acc_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 ovf, ovf_nxt;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 accept;

  assign accept  = i_valid && o_ready;
  // One extra bit so the carry out of the accumulator is visible.
  assign sum_ext = {1'b0, acc} + AW1'(i_sum);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          cnt_nxt = cnt + CW'(1);
          ovf_nxt = ovf | sum_ext[ACC_WIDTH];
`ifdef SUM_ACCUMULATOR_SAT_EN
          if (ovf || sum_ext[ACC_WIDTH]) acc_nxt = '1;
          else                           acc_nxt = sum_ext[ACC_WIDTH-1:0];
`else
          acc_nxt = sum_ext[ACC_WIDTH-1:0];
`endif
          state_nxt = (cnt_nxt == CW'(COUNT)) ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (i_ready) begin
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Abort wins over both an input accept and an output handshake.
    if (i_clear) begin
      acc_nxt   = '0;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  assign o_total    = acc;
  assign o_count    = cnt;
  assign o_overflow = ovf;
  assign o_valid    = (state == HOLD);
  assign o_ready    = (state != HOLD);
endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench: default build, a 12-bit accumulator instance and a COUNT=1 instance.
module tb_sum_accumulator;
  logic clk, rst;

  // default instance
  logic [10:0] a_sum;
  logic        a_valid, a_clear, a_rdy_in;
  logic        a_ready, a_ovalid, a_ovf;
  logic [12:0] a_total;
  logic [2:0]  a_count;

  // ACC_WIDTH=12 instance
  logic [10:0] b_sum;
  logic        b_valid, b_clear, b_rdy_in;
  logic        b_ready, b_ovalid, b_ovf;
  logic [11:0] b_total;
  logic [2:0]  b_count;

  // COUNT=1 instance
  logic [10:0] c_sum;
  logic        c_valid, c_clear, c_rdy_in;
  logic        c_ready, c_ovalid, c_ovf;
  logic [12:0] c_total;
  logic [0:0]  c_count;

  int n_chk, n_fail;

  sum_accumulator dut_a (
    .i_clk(clk), .i_rst(rst), .i_sum(a_sum), .i_valid(a_valid), .o_ready(a_ready),
    .i_clear(a_clear), .o_total(a_total), .o_valid(a_ovalid), .i_ready(a_rdy_in),
    .o_count(a_count), .o_overflow(a_ovf));

  sum_accumulator #(.WIDTH(10), .COUNT(4), .ACC_WIDTH(12)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_sum(b_sum), .i_valid(b_valid), .o_ready(b_ready),
    .i_clear(b_clear), .o_total(b_total), .o_valid(b_ovalid), .i_ready(b_rdy_in),
    .o_count(b_count), .o_overflow(b_ovf));

  sum_accumulator #(.WIDTH(10), .COUNT(1), .ACC_WIDTH(13)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_sum(c_sum), .i_valid(c_valid), .o_ready(c_ready),
    .i_clear(c_clear), .o_total(c_total), .o_valid(c_ovalid), .i_ready(c_rdy_in),
    .o_count(c_count), .o_overflow(c_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge: present one beat on dut_a, return at the next falling edge.
  task automatic send_a(input logic [10:0] s);
    a_valid = 1'b1;
    a_sum   = s;
    @(negedge clk);
  endtask

  task automatic chk_a_idle(input string tag);
    chk({tag, "_valid"}, a_ovalid, 0);
    chk({tag, "_ready"}, a_ready, 1);
    chk({tag, "_total"}, a_total, 0);
    chk({tag, "_count"}, a_count, 0);
    chk({tag, "_ovf"},   a_ovf, 0);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1;
    a_sum = '0; a_valid = 0; a_clear = 0; a_rdy_in = 1;
    b_sum = '0; b_valid = 0; b_clear = 0; b_rdy_in = 1;
    c_sum = '0; c_valid = 0; c_clear = 0; c_rdy_in = 1;
    #3;
    chk_a_idle("rst");
    @(negedge clk);
    rst = 1'b0;

    // 1: back-to-back frame, o_ready low for exactly one cycle
    send_a(100); send_a(200);
    chk("t1_count2", a_count, 2);
    chk("t1_total2", a_total, 300);
    send_a(300); send_a(400);
    a_valid = 0;
    chk("t1_valid", a_ovalid, 1);
    chk("t1_total", a_total, 1000);
    chk("t1_ovf",   a_ovf, 0);
    chk("t1_ready", a_ready, 0);
    chk("t1_count", a_count, 4);
    @(negedge clk);
    chk_a_idle("t1_after");

    // 2: largest default frame still fits 13 bits
    for (int i = 0; i < 4; i++) send_a(2046);
    a_valid = 0;
    chk("t2_valid", a_ovalid, 1);
    chk("t2_total", a_total, 8184);
    chk("t2_ovf",   a_ovf, 0);
    @(negedge clk);

    // 3: 12-bit accumulator overflows
    for (int i = 0; i < 4; i++) begin
      b_valid = 1; b_sum = 2046;
      @(negedge clk);
    end
    b_valid = 0;
    chk("t3_valid", b_ovalid, 1);
`ifdef SUM_ACCUMULATOR_SAT_EN
    chk("t3_total", b_total, 4095);
`else
    chk("t3_total", b_total, 4088);
`endif
    chk("t3_ovf", b_ovf, 1);
    @(negedge clk);
    chk("t3_after_ovf", b_ovf, 0);

    // 4: back-pressure holds the result and ignores input
    a_rdy_in = 0;
    send_a(1); send_a(2); send_a(3); send_a(4);
    a_valid = 1; a_sum = 50;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", a_ovalid, 1);
      chk("t4_hold_total", a_total, 10);
      chk("t4_hold_ready", a_ready, 0);
      @(negedge clk);
    end
    a_valid = 0; a_rdy_in = 1;
    @(negedge clk);
    chk_a_idle("t4_hs");
    for (int i = 0; i < 4; i++) send_a(1);
    a_valid = 0;
    chk("t4_valid2", a_ovalid, 1);
    chk("t4_total2", a_total, 4);
    @(negedge clk);

    // 5: abort coincident with a beat drops it
    send_a(10); send_a(20);
    chk("t5_count2", a_count, 2);
    chk("t5_total2", a_total, 30);
    a_clear = 1; a_valid = 1; a_sum = 30;
    @(negedge clk);
    a_clear = 0; a_valid = 0;
    chk_a_idle("t5_clr");
    for (int i = 0; i < 4; i++) send_a(5);
    a_valid = 0;
    chk("t5_valid", a_ovalid, 1);
    chk("t5_total", a_total, 20);
    @(negedge clk);

    // 5b: abort while holding a result discards it
    a_rdy_in = 0;
    for (int i = 0; i < 4; i++) send_a(9);
    a_valid = 0;
    chk("t5b_valid", a_ovalid, 1);
    a_clear = 1;
    @(negedge clk);
    a_clear = 0; a_rdy_in = 1;
    chk_a_idle("t5b_clr");

    // 6: asynchronous reset mid-frame
    send_a(3); send_a(3);
    a_valid = 0;
    chk("t6_count2", a_count, 2);
    #2 rst = 1'b1;
    #1;
    chk_a_idle("t6_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_a_idle("t6_rel");

    // 6b: COUNT=1 completes on a single beat
    c_valid = 1; c_sum = 7;
    @(negedge clk);
    c_valid = 0;
    chk("t6_c1_valid", c_ovalid, 1);
    chk("t6_c1_total", c_total, 7);
    chk("t6_c1_ready", c_ready, 0);
    chk("t6_c1_count", c_count, 1);
    @(negedge clk);
    chk("t6_c1_after", c_ovalid, 0);
    chk("t6_c1_after_total", c_total, 0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
